// File: rtl/cpu_pkg.sv
// Shared decode constants, ALU control encodings, FSM states and the
// instruction decoder for the FakeCPU execution sequencer.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_AW  = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RS   = 3'd1;
    localparam logic [2:0] S_RT   = 3'd2;
    localparam logic [2:0] S_EXE  = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;

    typedef struct packed {
        logic              legal;
        logic [3:0]        alu_ctrl;
        logic              use_imm;
        logic              zext_imm;
        logic              chk_ovf;
        logic              wr_reg;
        logic [REG_AW-1:0] waddr;
        logic              is_lw;
        logic              is_sw;
        logic              is_blez;
        logic              is_j;
    } dec_t;

    // Pure decode of a latched instruction; illegal encodings write nothing.
    function automatic dec_t decode(input logic [INSTR_W-1:0] ins);
        dec_t d;
        d          = '0;
        d.legal    = 1'b1;
        d.use_imm  = 1'b1;
        d.wr_reg   = 1'b1;
        d.waddr    = ins[20:16];
        d.alu_ctrl = ALU_ADD;
        case (ins[31:26])
            OP_RTYPE: begin
                d.use_imm = 1'b0;
                d.waddr   = ins[15:11];
                case (ins[5:0])
                    F_ADD:  begin d.alu_ctrl = ALU_ADD; d.chk_ovf = 1'b1; end
                    F_ADDU: d.alu_ctrl = ALU_ADD;
                    F_SUB:  begin d.alu_ctrl = ALU_SUB; d.chk_ovf = 1'b1; end
                    F_SUBU: d.alu_ctrl = ALU_SUB;
                    F_AND:  d.alu_ctrl = ALU_AND;
                    F_OR:   d.alu_ctrl = ALU_OR;
                    F_XOR:  d.alu_ctrl = ALU_XOR;
                    F_NOR:  d.alu_ctrl = ALU_NOR;
                    F_SLT:  d.alu_ctrl = ALU_SLT;
                    F_SLTU: d.alu_ctrl = ALU_SLTU;
                    default: begin d.legal = 1'b0; d.wr_reg = 1'b0; end
                endcase
            end
            OP_ADDI:  d.chk_ovf  = 1'b1;
            OP_ADDIU: d.alu_ctrl = ALU_ADD;
            OP_SLTI:  d.alu_ctrl = ALU_SLT;
            OP_SLTIU: d.alu_ctrl = ALU_SLTU;
            OP_XORI:  begin d.alu_ctrl = ALU_XOR; d.zext_imm = 1'b1; end
            OP_BLEZ:  begin d.is_blez = 1'b1; d.wr_reg = 1'b0; end
            OP_J:     begin d.is_j = 1'b1; d.wr_reg = 1'b0; end
            OP_LW:    begin d.is_lw = 1'b1; d.wr_reg = 1'b0; end
            OP_SW:    begin d.is_sw = 1'b1; d.wr_reg = 1'b0; end
            default:  begin d.legal = 1'b0; d.wr_reg = 1'b0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/exec_sequencer_alu.sv
// Combinational integer ALU: add/sub with signed overflow flag, logic ops,
// signed and unsigned set-less-than.
module ALU
    import cpu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   ctrl_i,
    output logic [W-1:0] result_o,
    output logic         ovf_o
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        case (ctrl_i)
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
            end
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLT:  result_o = W'($signed(a_i) < $signed(b_i));
            ALU_SLTU: result_o = W'(a_i < b_i);
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle decode/execute sequencer: reads rs/rt over a synchronous
// register port, executes via the ALU, handles lw/sw, writes back, reports next PC.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 19,
    parameter int unsigned     DATA_W   = 32,
    parameter logic [ADDR_W-1:0] TRAP_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] pc,
    output logic              ok,
    output logic [ADDR_W-1:0] next_pc,
    output logic              trap,
    output logic              illegal,
    output logic [4:0]        reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_we,
    output logic [4:0]        reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    logic [2:0]        state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rs_q, rs_d;

    logic              ok_q, ok_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic              trap_q, trap_d;
    logic              illegal_q, illegal_d;
    logic [4:0]        reg_raddr_q, reg_raddr_d;
    logic              reg_we_q, reg_we_d;
    logic [4:0]        reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    dec_t              dec;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_target;
    logic              rs_le_zero;
    logic              exe_trap;
    logic [ADDR_W-1:0] exe_npc;

    assign dec     = decode(instr_q);
    assign imm16   = instr_q[15:0];
    assign imm_ext = dec.zext_imm ? DATA_W'(imm16) : DATA_W'($signed(imm16));
    // In EXE the register port already presents rt, so it feeds the ALU directly.
    assign alu_b   = dec.use_imm ? imm_ext : reg_rdata;

    ALU #(.W(DATA_W)) u_alu (
        .a_i      (rs_q),
        .b_i      (alu_b),
        .ctrl_i   (dec.alu_ctrl),
        .result_o (alu_res),
        .ovf_o    (alu_ovf)
    );

    assign pc_inc     = pc_q + ADDR_W'(1);
    assign br_target  = pc_inc + ADDR_W'($signed(imm16));
    assign rs_le_zero = rs_q[DATA_W-1] || (rs_q == '0);
    assign exe_trap   = !dec.legal || (dec.chk_ovf && alu_ovf);

    always_comb begin
        if (exe_trap)                      exe_npc = TRAP_VEC;
        else if (dec.is_j)                 exe_npc = instr_q[ADDR_W-1:0];
        else if (dec.is_blez && rs_le_zero) exe_npc = br_target;
        else                               exe_npc = pc_inc;
    end

    // Next-state and registered-output logic; strobes default low, data holds.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        rs_d        = rs_q;
        ok_d        = 1'b0;
        trap_d      = 1'b0;
        illegal_d   = 1'b0;
        reg_we_d    = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        next_pc_d   = next_pc_q;
        reg_raddr_d = reg_raddr_q;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    instr_d     = instr;
                    pc_d        = pc;
                    reg_raddr_d = instr[25:21];
                    state_d     = S_RS;
                end
            end
            S_RS: begin
                reg_raddr_d = instr_q[20:16];
                state_d     = S_RT;
            end
            S_RT: begin
                rs_d    = reg_rdata;
                state_d = S_EXE;
            end
            S_EXE: begin
                if (!exe_trap && (dec.is_lw || dec.is_sw)) begin
                    state_d    = S_MEM;
                    mem_addr_d = ADDR_W'(alu_res);
                    mem_rd_d   = dec.is_lw;
                    mem_wr_d   = dec.is_sw;
                    if (dec.is_sw) mem_wdata_d = reg_rdata;
                end else begin
                    state_d     = S_WB;
                    ok_d        = 1'b1;
                    trap_d      = exe_trap;
                    illegal_d   = !dec.legal;
                    next_pc_d   = exe_npc;
                    reg_we_d    = !exe_trap && dec.wr_reg && (dec.waddr != '0);
                    reg_waddr_d = dec.waddr;
                    reg_wdata_d = alu_res;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d   = S_WB;
                    ok_d      = 1'b1;
                    next_pc_d = pc_inc;
                    if (dec.is_lw) begin
                        reg_we_d    = (instr_q[20:16] != '0);
                        reg_waddr_d = instr_q[20:16];
                        reg_wdata_d = mem_rdata;
                    end
                end else begin
                    mem_rd_d = mem_rd_q;
                    mem_wr_d = mem_wr_q;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            pc_q        <= '0;
            rs_q        <= '0;
            ok_q        <= 1'b0;
            next_pc_q   <= '0;
            trap_q      <= 1'b0;
            illegal_q   <= 1'b0;
            reg_raddr_q <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            rs_q        <= rs_d;
            ok_q        <= ok_d;
            next_pc_q   <= next_pc_d;
            trap_q      <= trap_d;
            illegal_q   <= illegal_d;
            reg_raddr_q <= reg_raddr_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ok        = ok_q;
    assign next_pc   = next_pc_q;
    assign trap      = trap_q;
    assign illegal   = illegal_q;
    assign reg_raddr = reg_raddr_q;
    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
